branch_update_sched: RTL and testbench
======================================

BRANCH_UPDATE_SCHED -- requirements
Module: branch_update_sched

Interface
REQ-001 Parameter DEPTH, default 4, update-queue entries (power of two, >=2) SHALL be supported.
REQ-002 Parameter STARVE_LIMIT, default 8, maximum consecutive cycles a queued update may lose arbitration to lookups.
REQ-003 clk  in  1  sole clock; all state rises on posedge clk.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 lookup_val  in  1  fetch requests a prediction this cycle.
REQ-006 lookup_pc  in  32  fetch PC.
REQ-007 lookup_rdy  out  1  lookup granted this cycle; lookup_pred valid.
REQ-008 lookup_pred  out  1  prediction returned to fetch.
REQ-009 upd_val  in  1  execute presents a resolved branch.
REQ-010 upd_rdy  out  1  queue accepts upd_* this cycle.
REQ-011 upd_pc  in  32  resolved branch PC.
REQ-012 upd_taken  in  1  resolved direction.
REQ-013 pred_pc  out  32  PC driven to the gshare predictor.
REQ-014 pred_update_en  out  1  predictor update strobe.
REQ-015 pred_update_val  out  1  predictor update direction.
REQ-016 pred_prediction  in  1  predictor combinational output for pred_pc.
REQ-017 count  out  $clog2(DEPTH)+1  queued-entry count.

Function
REQ-018 Updates SHALL be held in a DEPTH-entry FIFO of {pc, taken}; push when upd_val && upd_rdy.
REQ-019 upd_rdy SHALL equal (count < DEPTH); no same-cycle push-when-full via pop.
REQ-020 No bypass: a pushed entry SHALL issue no earlier than the following cycle.
REQ-021 Each cycle exactly one of {UPDATE, LOOKUP, IDLE} grant SHALL occur, decided combinationally from current state.
REQ-022 UPDATE grant: pred_pc=head.pc, pred_update_en=1, pred_update_val=head.taken, pop head, lookup_rdy=0.
REQ-023 LOOKUP grant: pred_pc=lookup_pc, pred_update_en=0, lookup_rdy=1, lookup_pred=pred_prediction (same cycle).
REQ-024 IDLE: pred_update_en=0, lookup_rdy=0, pred_pc=0, lookup_pred=0.
REQ-025 FSM states NORMAL, DRAIN.
REQ-026 NORMAL: UPDATE if count>0 and (!lookup_val or starve==STARVE_LIMIT); else LOOKUP if lookup_val; else IDLE.
REQ-027 NORMAL->DRAIN when count==DEPTH at cycle start (transition takes effect next cycle).
REQ-028 DRAIN: UPDATE every cycle regardless of lookup_val; lookup_rdy=0.
REQ-029 DRAIN->NORMAL when post-pop count <= DEPTH/2.
REQ-030 starve counter: +1 (saturating at STARVE_LIMIT) on each LOOKUP grant with count>0; cleared on any UPDATE grant or when count==0.
REQ-031 Simultaneous push and pop SHALL leave count unchanged; head/tail pointers wrap modulo DEPTH.
REQ-032 pred_update_en SHALL never assert with count==0.

Reset
REQ-033 Asserting reset (low) SHALL immediately clear count, pointers, starve counter, state=NORMAL; upd_rdy=1, lookup_rdy=0, pred_update_en=0, pred_pc=0, lookup_pred=0.
REQ-034 Reset mid-operation SHALL discard queued updates without issuing them.
REQ-035 FIFO data storage need not be reset.

Structure
REQ-036 State encoding enum and the {pc, taken} entry struct SHALL live in a shared lab4_branch package.
REQ-037 The FIFO SHALL be a sub-module branch_update_queue (storage, pointers, count); arbitration/FSM in the parent.

Verification
REQ-038 Lookup-only: lookup_val=1, pc=0x100, queue empty -> lookup_rdy=1 same cycle, pred_update_en=0, lookup_pred tracks pred_prediction.
REQ-039 Idle-slot update: push {0x200,1}, next cycle lookup_val=0 -> pred_update_en=1, pred_pc=0x200, pred_update_val=1, count 1->0.
REQ-040 Starvation: one queued entry, lookup_val held 1 -> 8 LOOKUP grants then UPDATE on 9th cycle, lookup_rdy=0 that cycle.
REQ-041 Full/drain: push 4 entries while lookup_val=1 -> upd_rdy=0 at count=4, DRAIN issues 2 consecutive updates, NORMAL with count=2.
REQ-042 Simultaneous push/pop at count=2 -> count stays 2, FIFO order preserved across pointer wrap.
REQ-043 Reset asserted with count=3 in DRAIN -> outputs cleared asynchronously, no update issued after release, state NORMAL.

Source files
------------

// File: rtl/branch_update_sched_pkg.sv
// Shared types for the branch-predictor update scheduler: FSM states,
// per-cycle grant kinds and the queued {pc, taken} update entry.
package lab4_branch;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } sched_state_e;

  typedef enum logic [1:0] {
    GNT_IDLE   = 2'd0,
    GNT_LOOKUP = 2'd1,
    GNT_UPDATE = 2'd2
  } grant_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } upd_entry_t;

endpackage

// File: rtl/branch_update_queue.sv
// DEPTH-entry FIFO of resolved-branch updates. The parent guarantees that
// push only happens when not full and pop only when not empty.
module branch_update_queue
  import lab4_branch::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  upd_entry_t               push_entry,
  input  logic                     pop,
  output upd_entry_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  upd_entry_t      r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Storage is deliberately left out of reset; only pointers/count matter.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/branch_update_sched.sv
// Arbitrates the single gshare port between fetch lookups and queued
// execute-stage updates, with starvation limit and a full-queue drain mode.
module branch_update_sched
  import lab4_branch::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_val,
  input  logic [31:0]              lookup_pc,
  output logic                     lookup_rdy,
  output logic                     lookup_pred,
  input  logic                     upd_val,
  output logic                     upd_rdy,
  input  logic [31:0]              upd_pc,
  input  logic                     upd_taken,
  output logic [31:0]              pred_pc,
  output logic                     pred_update_en,
  output logic                     pred_update_val,
  input  logic                     pred_prediction,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sched_state_e   r_state;
  logic [SW-1:0]  r_starve;

  grant_e         w_grant;
  upd_entry_t     w_head;
  upd_entry_t     w_push_entry;
  logic [CW-1:0]  w_count;
  logic           w_push;
  logic           w_pop;
  logic           w_not_empty;
  logic           w_starved;

  assign w_push_entry = '{pc: upd_pc, taken: upd_taken};
  assign upd_rdy      = (w_count < CW'(DEPTH));
  assign w_push       = upd_val && upd_rdy;
  assign w_pop        = (w_grant == GNT_UPDATE);
  assign w_not_empty  = (w_count != '0);
  assign w_starved    = (r_starve == SW'(STARVE_LIMIT));

  branch_update_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .head       (w_head),
    .count      (w_count)
  );

  // Gating with reset makes the outputs drop the instant reset asserts,
  // independent of whatever fetch is still presenting.
  always_comb begin
    w_grant = GNT_IDLE;
    if (reset) begin
      if (r_state == ST_DRAIN) begin
        if (w_not_empty) begin
          w_grant = GNT_UPDATE;
        end
      end else if (w_not_empty && (!lookup_val || w_starved)) begin
        w_grant = GNT_UPDATE;
      end else if (lookup_val) begin
        w_grant = GNT_LOOKUP;
      end
    end
  end

  always_comb begin
    pred_pc = '0;
    case (w_grant)
      GNT_UPDATE: pred_pc = w_head.pc;
      GNT_LOOKUP: pred_pc = lookup_pc;
      default:    pred_pc = '0;
    endcase
  end

  assign pred_update_en  = (w_grant == GNT_UPDATE);
  assign pred_update_val = (w_grant == GNT_UPDATE) && w_head.taken;
  assign lookup_rdy      = (w_grant == GNT_LOOKUP);
  assign lookup_pred     = (w_grant == GNT_LOOKUP) && pred_prediction;
  assign count           = w_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if ((w_grant == GNT_UPDATE) || !w_not_empty) begin
      r_starve <= '0;
    end else if ((w_grant == GNT_LOOKUP) && !w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // DRAIN pops every cycle, so count <= DEPTH/2+1 now means the post-pop
  // count is at or below half full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_NORMAL;
    end else begin
      case (r_state)
        ST_NORMAL: begin
          if (w_count == CW'(DEPTH)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_count <= CW'(DEPTH / 2 + 1)) begin
            r_state <= ST_NORMAL;
          end
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_update_sched.sv
// Randomized self-checking bench for branch_update_sched against a
// queue-based behavioural model of the arbitration rules.
module tb_branch_update_sched;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        lookup_val;
  logic [31:0] lookup_pc;
  logic        lookup_rdy;
  logic        lookup_pred;
  logic        upd_val;
  logic        upd_rdy;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] pred_pc;
  logic        pred_update_en;
  logic        pred_update_val;
  logic        pred_prediction;
  logic [$clog2(DEPTH):0] count;

  branch_update_sched #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_val      (lookup_val),
    .lookup_pc       (lookup_pc),
    .lookup_rdy      (lookup_rdy),
    .lookup_pred     (lookup_pred),
    .upd_val         (upd_val),
    .upd_rdy         (upd_rdy),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .pred_pc         (pred_pc),
    .pred_update_en  (pred_update_en),
    .pred_update_val (pred_update_val),
    .pred_prediction (pred_prediction),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {pc, taken}, drain flag, starvation count.
  logic [32:0] mq[$];
  bit          m_drain  = 0;
  int          m_starve = 0;

  bit obs_lrdy;
  bit obs_en;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_drain  = 0;
    m_starve = 0;
  endtask

  // One clock: drive, check combinational outputs mid-cycle, advance model.
  task automatic do_cycle(input bit lv, input logic [31:0] lpc,
                          input bit uv, input logic [31:0] upc, input bit ut);
    int sz;
    int g;
    logic [31:0] exp_pc;
    lookup_val      = lv;
    lookup_pc       = lpc;
    upd_val         = uv;
    upd_pc          = upc;
    upd_taken       = ut;
    pred_prediction = 1'($urandom_range(0, 1));
    #2;
    sz = mq.size();
    if (m_drain)                                              g = (sz > 0) ? 2 : 0;
    else if (sz > 0 && (!lv || m_starve == STARVE_LIMIT))     g = 2;
    else if (lv)                                              g = 1;
    else                                                      g = 0;
    exp_pc = (g == 2) ? mq[0][32:1] : (g == 1) ? lpc : 32'h0;
    check_val("upd_rdy", 64'(upd_rdy), 64'(sz < DEPTH));
    check_val("count", 64'(count), 64'(sz));
    check_val("lookup_rdy", 64'(lookup_rdy), 64'(g == 1));
    check_val("lookup_pred", 64'(lookup_pred), 64'((g == 1) && pred_prediction));
    check_val("upd_en", 64'(pred_update_en), 64'(g == 2));
    check_val("pred_pc", 64'(pred_pc), 64'(exp_pc));
    if (g == 2) check_val("upd_val", 64'(pred_update_val), 64'(mq[0][0]));
    obs_lrdy = lookup_rdy;
    obs_en   = pred_update_en;
    @(posedge clk);
    if (g == 2) void'(mq.pop_front());
    if (uv && sz < DEPTH) mq.push_back({upc, ut});
    if (g == 2 || sz == 0)  m_starve = 0;
    else if (g == 1)        m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
    if (!m_drain)           m_drain = (sz == DEPTH);
    else if (sz - 1 <= DEPTH / 2) m_drain = 0;
    #1;
  endtask

  task automatic drain_empty();
    for (int i = 0; i < 20 && mq.size() > 0; i++) do_cycle(0, 32'h0, 0, 32'h0, 0);
  endtask

  initial begin
    int nlook;
    int upd_cycle;
    reset = 1'b0;
    lookup_val = 1'b1; lookup_pc = 32'h1234; upd_val = 1'b1;
    upd_pc = 32'h0; upd_taken = 1'b0; pred_prediction = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_lookup_rdy", 64'(lookup_rdy), 64'(0));
    check_val("rst_upd_rdy", 64'(upd_rdy), 64'(1));
    check_val("rst_count", 64'(count), 64'(0));
    check_val("rst_upd_en", 64'(pred_update_en), 64'(0));
    check_val("rst_pred_pc", 64'(pred_pc), 64'(0));
    check_val("rst_lookup_pred", 64'(lookup_pred), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // Lookup-only on an empty queue
    for (int i = 0; i < 4; i++) do_cycle(1, 32'h100, 0, 32'h0, 0);

    // Idle-slot update
    do_cycle(0, 32'h0, 1, 32'h200, 1);
    do_cycle(0, 32'h0, 0, 32'h0, 0);
    check_val("idle_upd_seen", 64'(obs_en), 64'(1));
    check_val("idle_upd_count", 64'(count), 64'(0));

    // Starvation: one entry, lookups held
    do_cycle(1, 32'h400, 1, 32'h300, 0);
    nlook = 0; upd_cycle = 0;
    for (int i = 1; i <= 12 && upd_cycle == 0; i++) begin
      do_cycle(1, 32'h400 + 32'(i), 0, 32'h0, 0);
      if (obs_lrdy) nlook++;
      if (obs_en) upd_cycle = i;
    end
    check_val("starve_lookups", 64'(nlook), 64'(STARVE_LIMIT));
    check_val("starve_upd_cycle", 64'(upd_cycle), 64'(STARVE_LIMIT + 1));

    // Full then drain
    drain_empty();
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 32'h500, 1, 32'h600 + 32'(i * 4), i[0]);
    do_cycle(1, 32'h504, 1, 32'h700, 1);
    check_val("full_lookup", 64'(obs_lrdy), 64'(1));
    do_cycle(1, 32'h508, 0, 32'h0, 0);
    check_val("drain_upd1", 64'(obs_en), 64'(1));
    do_cycle(1, 32'h50c, 0, 32'h0, 0);
    check_val("drain_upd2", 64'(obs_en), 64'(1));
    check_val("drain_exit_count", 64'(count), 64'(2));

    // Simultaneous push/pop at count 2, across pointer wrap
    for (int i = 0; i < 6; i++) do_cycle(0, 32'h0, 1, 32'h800 + 32'(i * 4), ~i[0]);
    check_val("pushpop_count", 64'(count), 64'(2));

    // Reset while draining with three entries queued
    drain_empty();
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 32'h900, 1, 32'hA00 + 32'(i * 4), 1);
    do_cycle(1, 32'h904, 0, 32'h0, 0);
    do_cycle(1, 32'h908, 0, 32'h0, 0);
    check_val("pre_rst_count", 64'(count), 64'(3));
    lookup_val = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check_val("async_count", 64'(count), 64'(0));
    check_val("async_upd_en", 64'(pred_update_en), 64'(0));
    check_val("async_lookup_rdy", 64'(lookup_rdy), 64'(0));
    check_val("async_pred_pc", 64'(pred_pc), 64'(0));
    check_val("async_upd_rdy", 64'(upd_rdy), 64'(1));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) do_cycle(0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) do_cycle(1, 32'hB00, 0, 32'h0, 0);

    // Randomized traffic in phases of differing lookup/update pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        bit lv;
        bit uv;
        lv = ($urandom_range(0, 3) < ph + 1);
        uv = ($urandom_range(0, 3) < 4 - ph) || (ph == 3 && $urandom_range(0, 1) == 1);
        do_cycle(lv, 32'($urandom), uv, 32'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
